uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between two byte sources: the recognition-result path and the debug/status path. It arbitrates round-robin and hands each winning byte to the transmitter core over a start/busy handshake. After each frame it enforces an idle gap, counted in baud ticks from the baud-rate tick generator. A transmitter that never responds is detected by a timeout.

---
 rtl/uart_tx_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte sources,
// with start/busy handshake, start timeout and a post-frame idle gap in baud ticks.
module uart_tx_scheduler #(
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       baud_tick,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       grant_id,
    output logic       sched_busy,
    output logic       tx_timeout
);

    localparam logic [7:0]  GAP_LIMIT     = 8'(GAP_TICKS);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_SEND      = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        grant_id_r;
    logic        last_grant_r;
    logic [7:0]  tx_data_r;
    logic        tx_start_r;
    logic        req0_ready_r;
    logic        req1_ready_r;
    logic        sched_busy_r;
    logic        tx_timeout_r;
    logic [15:0] timeout_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        tick_d_r;

    logic        winner_s;
    logic        granted_valid_s;
    logic [7:0]  granted_data_s;
    logic        tick_rise_s;
    logic        timeout_hit_s;
    logic        req0_ready_next_s;
    logic        req1_ready_next_s;
    logic        tx_start_next_s;
    logic        sched_busy_next_s;
    logic        tx_timeout_next_s;

    // Arbitration, granted-source selection and tick edge detection
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_s = ~last_grant_r;
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        granted_valid_s = grant_id_r ? req1_valid : req0_valid;
        granted_data_s  = grant_id_r ? req1_data  : req0_data;
        tick_rise_s     = baud_tick & ~tick_d_r;
        timeout_hit_s   = (timeout_cnt_r + 16'd1) == TIMEOUT_LIMIT;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && (req0_valid || req1_valid)) state_next_s = ST_LOAD;
                else                                         state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (granted_valid_s) state_next_s = ST_START;
                else                 state_next_s = ST_IDLE;
            end
            ST_START: state_next_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy)            state_next_s = ST_SEND;
                else if (timeout_hit_s) state_next_s = ST_IDLE;
                else                    state_next_s = ST_WAIT_BUSY;
            end
            ST_SEND: begin
                if (tx_busy)                 state_next_s = ST_SEND;
                else if (GAP_LIMIT == 8'd0)  state_next_s = ST_IDLE;
                else                         state_next_s = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LIMIT) state_next_s = ST_IDLE;
                else                        state_next_s = ST_GAP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output logic: values the output registers take on the coming edge
    always_comb begin
        req0_ready_next_s = (state_next_s == ST_LOAD) && (winner_s == 1'b0);
        req1_ready_next_s = (state_next_s == ST_LOAD) && (winner_s == 1'b1);
        tx_start_next_s   = (state_next_s == ST_START);
        sched_busy_next_s = (state_next_s != ST_IDLE);
        tx_timeout_next_s = (state_r == ST_WAIT_BUSY) && !tx_busy && timeout_hit_s;
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            tx_start_r   <= 1'b0;
            sched_busy_r <= 1'b0;
            tx_timeout_r <= 1'b0;
        end else begin
            req0_ready_r <= req0_ready_next_s;
            req1_ready_r <= req1_ready_next_s;
            tx_start_r   <= tx_start_next_s;
            sched_busy_r <= sched_busy_next_s;
            tx_timeout_r <= tx_timeout_next_s;
        end
    end

    // Grant bookkeeping, data latch, timeout and gap counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id_r    <= 1'b0;
            last_grant_r  <= 1'b1;
            tx_data_r     <= 8'h00;
            timeout_cnt_r <= 16'd0;
            gap_cnt_r     <= 8'd0;
            tick_d_r      <= 1'b0;
        end else begin
            tick_d_r <= baud_tick;
            if ((state_r == ST_IDLE) && (state_next_s == ST_LOAD)) begin
                grant_id_r <= winner_s;
            end
            // A withdrawn request leaves last_grant untouched so fairness is kept
            if ((state_r == ST_LOAD) && granted_valid_s) begin
                tx_data_r    <= granted_data_s;
                last_grant_r <= grant_id_r;
            end
            if (state_r == ST_START) begin
                timeout_cnt_r <= 16'd0;
            end else if ((state_r == ST_WAIT_BUSY) && !tx_busy) begin
                timeout_cnt_r <= timeout_cnt_r + 16'd1;
            end
            if (state_r == ST_SEND) begin
                gap_cnt_r <= 8'd0;
            end else if ((state_r == ST_GAP) && tick_rise_s && (gap_cnt_r != GAP_LIMIT)) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end
        end
    end

    assign req0_ready = req0_ready_r;
    assign req1_ready = req1_ready_r;
    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign grant_id   = grant_id_r;
    assign sched_busy = sched_busy_r;
    assign tx_timeout = tx_timeout_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of single-frame vectors plus
// hand-written sequences for contention, timeout, gap, withdrawal and reset.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       baud_tick = 1'b0, tx_busy = 1'b0;
    logic       req0_ready, req1_ready, tx_start, grant_id, sched_busy, tx_timeout;
    logic [7:0] tx_data;

    logic       z_req0_valid = 1'b0, z_tx_busy = 1'b0;
    logic [7:0] z_req0_data = 8'h00;
    logic       z_req0_ready, z_req1_ready, z_tx_start, z_grant_id, z_sched_busy, z_tx_timeout;
    logic [7:0] z_tx_data;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int timeout_cnt = 0;
    int both_ready_cnt = 0;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_tx_scheduler #(.GAP_TICKS(2), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .baud_tick(baud_tick), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .sched_busy(sched_busy), .tx_timeout(tx_timeout)
    );

    uart_tx_scheduler #(.GAP_TICKS(0), .TIMEOUT(5)) dut_z (
        .clk(clk), .reset(reset),
        .req0_valid(z_req0_valid), .req0_data(z_req0_data), .req0_ready(z_req0_ready),
        .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(z_req1_ready),
        .baud_tick(1'b0), .tx_busy(z_tx_busy), .tx_start(z_tx_start), .tx_data(z_tx_data),
        .grant_id(z_grant_id), .sched_busy(z_sched_busy), .tx_timeout(z_tx_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_cnt <= start_cnt + 1;
        if (tx_timeout === 1'b1) timeout_cnt <= timeout_cnt + 1;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_ready_cnt <= both_ready_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; baud_tick = 1'b0; tx_busy = 1'b0;
        z_req0_valid = 1'b0; z_tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick_pulse();
        @(negedge clk) baud_tick = 1'b1;
        @(negedge clk) baud_tick = 1'b0;
    endtask

    task automatic wait_start(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One frame from IDLE: request, LOAD, START, busy for 3 cycles, then optional 2-tick gap
    task automatic run_vec(input vec_t v, input bit do_gap);
        @(negedge clk);
        req0_valid = v.v0; req0_data = v.d0; req1_valid = v.v1; req1_data = v.d1;
        @(posedge clk); #1;
        check("load_ready0", req0_ready, v.exp_grant == 1'b0);
        check("load_ready1", req1_ready, v.exp_grant == 1'b1);
        check("load_busy", sched_busy, 1'b1);
        @(posedge clk); #1;
        check("start_strobe", tx_start, 1'b1);
        check("start_data", tx_data, v.exp_data);
        check("start_grant", grant_id, v.exp_grant);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) tx_busy = 1'b0;
        @(posedge clk);
        if (do_gap) begin
            tick_pulse();
            tick_pulse();
            @(posedge clk); #1;
            check("gap_done_idle", sched_busy, 1'b0);
        end
    endtask

    initial begin
        bit ok;
        bit early;
        int snap;
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
        vecs[3] = '{1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1, 8'hC3};
        vecs[4] = '{1'b1, 8'h00, 1'b0, 8'h77, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'hFF, 1'b1, 8'h80, 1'b1, 8'h80};

        #1;
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant_id, 1'b0);
        check("rst_sched_busy", sched_busy, 1'b0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_timeout", tx_timeout, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

        // Contention: both valid continuously, grants alternate, gap of 2 ticks honoured
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
        for (int f = 0; f < 4; f++) begin
            wait_start(20, ok);
            check("cont_start_seen", ok, 1'b1);
            check("cont_data", tx_data, (f % 2 == 1) ? 8'h22 : 8'h11);
            check("cont_grant", grant_id, (f % 2 == 1) ? 1'b1 : 1'b0);
            @(negedge clk) tx_busy = 1'b1;
            repeat (10) @(posedge clk);
            @(negedge clk) tx_busy = 1'b0;
            @(posedge clk);
            snap = start_cnt;
            tick_pulse();
            repeat (3) @(posedge clk);
            #1;
            check("cont_gap_hold", start_cnt, snap);
            tick_pulse();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cont_end_idle", sched_busy, 1'b0);

        // Held tick: 4-cycle-high tick counts once with GAP_TICKS=2
        do_reset();
        run_vec('{1'b1, 8'h3E, 1'b0, 8'h00, 1'b0, 8'h3E}, 1'b0);
        @(negedge clk) baud_tick = 1'b1;
        repeat (4) @(negedge clk);
        baud_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_tick_once", sched_busy, 1'b1);
        tick_pulse();
        @(posedge clk); #1;
        check("held_tick_idle", sched_busy, 1'b0);

        // Zero gap: IDLE the cycle after tx_busy falls
        do_reset();
        @(negedge clk);
        z_req0_valid = 1'b1; z_req0_data = 8'h5E;
        @(posedge clk); #1;
        check("z_ready0", z_req0_ready, 1'b1);
        @(posedge clk); #1;
        check("z_start", z_tx_start, 1'b1);
        check("z_data", z_tx_data, 8'h5E);
        @(negedge clk);
        z_req0_valid = 1'b0; z_tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) z_tx_busy = 1'b0;
        @(posedge clk); #1;
        check("z_gap0_idle", z_sched_busy, 1'b0);

        // Timeout: core never responds
        do_reset();
        snap = timeout_cnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("to_start", tx_start, 1'b1);
        @(negedge clk) req0_valid = 1'b0;
        @(posedge clk);
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (tx_timeout !== 1'b0) early = 1'b1;
        end
        check("to_not_early", early, 1'b0);
        @(posedge clk); #1;
        check("to_pulse", tx_timeout, 1'b1);
        check("to_idle", sched_busy, 1'b0);
        @(posedge clk); #1;
        check("to_pulse_end", tx_timeout, 1'b0);
        check("to_count", timeout_cnt - snap, 1);
        run_vec('{1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h99}, 1'b1);

        // Withdrawn request: LOAD aborts, last_grant kept, req0 still wins contention
        do_reset();
        snap = start_cnt;
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 8'h44;
        @(posedge clk); #1;
        check("wd_ready1", req1_ready, 1'b1);
        @(negedge clk) req1_valid = 1'b0;
        @(posedge clk); #1;
        check("wd_no_start", tx_start, 1'b0);
        check("wd_idle", sched_busy, 1'b0);
        check("wd_start_cnt", start_cnt, snap);
        run_vec('{1'b1, 8'h12, 1'b1, 8'h34, 1'b0, 8'h12}, 1'b1);

        // Mid-frame reset during SEND
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hB7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mr_start", tx_start, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0; tx_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("mr_tx_data", tx_data, 8'h00);
        check("mr_busy", sched_busy, 1'b0);
        check("mr_outs", {tx_start, req0_ready, req1_ready, grant_id, tx_timeout}, 5'b00000);
        tx_busy = 1'b0;
        @(negedge clk) reset = 1'b0;
        run_vec('{1'b1, 8'hC8, 1'b1, 8'hD9, 1'b0, 8'hC8}, 1'b1);

        check("never_both_ready", both_ready_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
